// File: rtl/nxm_fir_pkg.sv
// Shared constants for the time-multiplexed FIR: default geometry, coefficient ROM, width helpers.
// Coefficients are signed Q1.15; entry k sits at bits [k*16 +: 16].
package nxm_fir_pkg;

   localparam int N_DEF     = 3;
   localparam int M_DEF     = 2;
   localparam int IN_I_DEF  = 2;
   localparam int IN_F_DEF  = 10;
   localparam int H_I_DEF   = 1;
   localparam int H_F_DEF   = 15;
   localparam int OUT_I_DEF = 2;
   localparam int OUT_F_DEF = 10;
   localparam int NCOEF     = 64;

   localparam logic [NCOEF*16-1:0] COEFFS = {
      {58{16'h0000}},
      16'h0400, 16'hC000, 16'h0800, 16'h1000, 16'h2000, 16'h4000
   };

   // Full-precision product plus enough headroom to sum every tap without overflow.
   function automatic int acc_w(input int in_w, input int h_w, input int taps);
      return in_w + h_w + $clog2(taps);
   endfunction

   function automatic int srl_segs(input int m);
      return (m + 15) / 16;
   endfunction

endpackage

// File: rtl/nxm_fir_lane.sv
// One MAC lane: M-deep addressable sample shift register, coefficient select and multiplier.
// Product is combinational from the addressed sample; the oldest sample cascades to the next lane.
module nxm_fir_lane
   import nxm_fir_pkg::*;
#(
   parameter int LANE = 0,
   parameter int M    = M_DEF,
   parameter int IW   = IN_I_DEF + IN_F_DEF,
   parameter int HW   = H_I_DEF + H_F_DEF,
   parameter int NSRL = srl_segs(M),
   parameter int LML  = $clog2(NSRL) + 4,
   parameter logic [NCOEF*HW-1:0] ROM = nxm_fir_pkg::COEFFS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  shift,
   input  logic signed [IW-1:0]  din,
   input  logic [LML-1:0]        addr,
   output logic signed [IW+HW-1:0] prod,
   output logic signed [IW-1:0]  cascade
);

   localparam int DEPTH = 16 * NSRL;
   localparam int PW    = IW + HW;

   logic signed [IW-1:0] sr [DEPTH];
   logic [LML-1:0]       sel;
   logic signed [HW-1:0] coef;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
      end else if (shift) begin
         sr[0] <= din;
         for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
   end

   // Clamp the address so an idle count never walks past this lane's slice of the ROM.
   always_comb begin
      sel  = (int'(addr) < M) ? addr : '0;
      coef = ROM[(LANE*M + int'(sel))*HW +: HW];
   end

   assign prod    = PW'(sr[sel]) * PW'(coef);
   assign cascade = sr[M-1];

endmodule

// File: rtl/nxm_fir.sv
// N-lane time-multiplexed FIR with N*M taps; each start accepts one sample.
// Output is written M enabled cycles after the start and held until the next completion.
module nxm_fir
   import nxm_fir_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int M     = M_DEF,
   parameter int IN_I  = IN_I_DEF,
   parameter int IN_F  = IN_F_DEF,
   parameter int H_I   = H_I_DEF,
   parameter int H_F   = H_F_DEF,
   parameter int OUT_I = OUT_I_DEF,
   parameter int OUT_F = OUT_F_DEF,
   parameter int NSRL  = srl_segs(M),
   parameter int LML   = $clog2(NSRL) + 4,
   parameter logic [NCOEF*(H_I+H_F)-1:0] ROM = nxm_fir_pkg::COEFFS
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          EN,
   input  logic                          start,
   input  logic signed [IN_I+IN_F-1:0]   in,
   output logic signed [OUT_I+OUT_F-1:0] out
);

   localparam int IW = IN_I + IN_F;
   localparam int HW = H_I + H_F;
   localparam int OW = OUT_I + OUT_F;
   localparam int PW = IW + HW;
   localparam int AW = acc_w(IW, HW, N*M);
   localparam int SH = IN_F + H_F - OUT_F;
   localparam int TW = AW - SH;
   localparam int CW = LML + 1;

   logic [CW-1:0]        count;
   logic                 busy;
   logic                 shift;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum;
   logic signed [PW-1:0] prod    [N];
   logic signed [IW-1:0] casc    [N];
   logic signed [IW-1:0] lane_in [N];
   logic signed [TW-1:0] trunc;
   logic [TW-OW:0]       hi;
   logic [OW-1:0]        sat;

   assign shift = EN & start;

   for (genvar i = 0; i < N; i++) begin : g_lane
      if (i == 0) begin : g_head
         assign lane_in[i] = in;
      end else begin : g_chain
         assign lane_in[i] = casc[i-1];
      end

      nxm_fir_lane #(
         .LANE(i), .M(M), .IW(IW), .HW(HW), .NSRL(NSRL), .LML(LML), .ROM(ROM)
      ) u_lane (
         .clk    (CLK),
         .rst_n  (RST),
         .shift  (shift),
         .din    (lane_in[i]),
         .addr   (count[LML-1:0]),
         .prod   (prod[i]),
         .cascade(casc[i])
      );
   end

   always_comb begin
      sum = acc;
      for (int i = 0; i < N; i++) sum = sum + AW'(prod[i]);
   end

   // Dropping the low SH bits is an arithmetic shift (floor); saturate when the
   // bits above the output sign are not all copies of it.
   always_comb begin
      trunc = sum[AW-1:SH];
      hi    = trunc[TW-1:OW-1];
      if ((&hi) | ~(|hi)) sat = trunc[OW-1:0];
      else                sat = {trunc[TW-1], {(OW-1){~trunc[TW-1]}}};
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         count <= '0;
         busy  <= 1'b0;
         acc   <= '0;
         out   <= '0;
      end else if (EN) begin
         if (start) begin
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
         end else if (busy) begin
            acc <= sum;
            if (count == CW'(M-1)) begin
               out   <= sat;
               busy  <= 1'b0;
               count <= CW'(M);
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nxm_fir.sv
// Bench for nxm_fir: three instances (3x2 impulse ROM, 2x3 impulse ROM, 3x2 all-max ROM)
// share one stimulus stream; expectations come from a tap-history model pushed per start.
module tb_nxm_fir;

   localparam logic [1023:0] IMP_ROM = {{58{16'h0000}},
      16'h0400, 16'hC000, 16'h0800, 16'h1000, 16'h2000, 16'h4000};
   localparam logic [1023:0] SAT_ROM = {64{16'h7FFF}};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        start;
   logic [11:0] din;
   logic [11:0] out_a, out_b, out_c;

   int          checks   = 0;
   int          failures = 0;
   int          hist  [6];
   int          imp_c [6];
   logic [11:0] qa[$], qb[$], qc[$];
   logic [11:0] last_a, last_b, exp_a, exp_b, exp_c;

   always #5 clk = ~clk;

   nxm_fir #(.N(3), .M(2), .ROM(IMP_ROM)) u_a (
      .CLK(clk), .RST(rst), .EN(en), .start(start), .in(din), .out(out_a));
   nxm_fir #(.N(2), .M(3), .ROM(IMP_ROM)) u_b (
      .CLK(clk), .RST(rst), .EN(en), .start(start), .in(din), .out(out_b));
   nxm_fir #(.N(3), .M(2), .ROM(SAT_ROM)) u_c (
      .CLK(clk), .RST(rst), .EN(en), .start(start), .in(din), .out(out_c));

   function automatic logic [11:0] model(input bit sat_rom);
      longint acc = 0;
      longint s;
      for (int k = 0; k < 6; k++)
         acc += longint'(hist[k]) * longint'(sat_rom ? 32767 : imp_c[k]);
      s = acc >>> 15;
      if (s > 2047)  s = 2047;
      if (s < -2048) s = -2048;
      return s[11:0];
   endfunction

   task automatic shift_hist(input logic [11:0] x);
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(x));
   endtask

   // One accepted start; returns just after the accepting edge.
   task automatic pulse(input logic [11:0] x);
      @(negedge clk);
      start = 1'b1;
      din   = x;
      shift_hist(x);
      qa.push_back(model(1'b0));
      qb.push_back(model(1'b0));
      qc.push_back(model(1'b1));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_q();
      qa.delete(); qb.delete(); qc.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; start = 1'b1; din = 12'h3FF;
      for (int k = 0; k < 6; k++) hist[k] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (out_a !== 12'h000) begin failures++; $display("FAIL reset_a got=%h exp=000", out_a); end
      checks++; if (out_b !== 12'h000) begin failures++; $display("FAIL reset_b got=%h exp=000", out_b); end
      checks++; if (out_c !== 12'h000) begin failures++; $display("FAIL reset_c got=%h exp=000", out_c); end
      rst = 1'b1; start = 1'b0; din = 12'h000;
      clear_q();
      pulse(12'h000);
      repeat (3) @(negedge clk);
      exp_c = qc.pop_front();
      checks++; if (out_c !== exp_c) begin failures++; $display("FAIL reset_noshift_c got=%h exp=%h", out_c, exp_c); end
      exp_a = qa.pop_front();
      checks++; if (out_a !== exp_a) begin failures++; $display("FAIL reset_noshift_a got=%h exp=%h", out_a, exp_a); end
      last_a = exp_a;
      last_b = qb.pop_front();
   endtask

   task automatic test_impulse();
      logic [11:0] seq [6];
      seq[0] = 12'h400;
      for (int k = 1; k < 6; k++) seq[k] = 12'h000;
      clear_q();
      for (int s = 0; s < 6; s++) begin
         pulse(seq[s]);
         exp_a = qa.pop_front();
         exp_b = qb.pop_front();
         @(negedge clk);
         checks++; if (out_a !== last_a) begin failures++; $display("FAIL imp_a_early s=%0d got=%h exp=%h", s, out_a, last_a); end
         checks++; if (out_b !== last_b) begin failures++; $display("FAIL imp_b_early1 s=%0d got=%h exp=%h", s, out_b, last_b); end
         @(negedge clk);
         checks++; if (out_a !== exp_a) begin failures++; $display("FAIL imp_a s=%0d got=%h exp=%h", s, out_a, exp_a); end
         checks++; if (out_b !== last_b) begin failures++; $display("FAIL imp_b_early2 s=%0d got=%h exp=%h", s, out_b, last_b); end
         @(negedge clk);
         checks++; if (out_b !== exp_b) begin failures++; $display("FAIL imp_b s=%0d got=%h exp=%h", s, out_b, exp_b); end
         last_a = exp_a;
         last_b = exp_b;
      end
   endtask

   task automatic test_saturation();
      clear_q();
      for (int s = 0; s < 12; s++) begin
         pulse(s < 6 ? 12'h7FF : 12'h800);
         repeat (3) @(negedge clk);
         exp_c = qc.pop_front();
         checks++; if (out_c !== exp_c) begin failures++; $display("FAIL sat_c s=%0d got=%h exp=%h", s, out_c, exp_c); end
      end
      clear_q();
      last_a = out_a;
      last_b = out_b;
   endtask

   task automatic test_en_hold();
      clear_q();
      pulse(12'h155);
      exp_a = qa.pop_front();
      exp_b = qb.pop_front();
      @(negedge clk);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         din   = 12'h7FF;
         @(negedge clk);
         checks++; if (out_a !== last_a) begin failures++; $display("FAIL hold_a k=%0d got=%h exp=%h", k, out_a, last_a); end
      end
      start = 1'b0;
      en    = 1'b1;
      @(negedge clk);
      checks++; if (out_a !== exp_a) begin failures++; $display("FAIL hold_resume_a got=%h exp=%h", out_a, exp_a); end
      checks++; if (out_b !== last_b) begin failures++; $display("FAIL hold_b_early got=%h exp=%h", out_b, last_b); end
      @(negedge clk);
      checks++; if (out_b !== exp_b) begin failures++; $display("FAIL hold_resume_b got=%h exp=%h", out_b, exp_b); end
      last_a = exp_a;
      last_b = exp_b;
   endtask

   task automatic test_back_to_back();
      clear_q();
      @(negedge clk);
      start = 1'b1; din = 12'h300;
      shift_hist(12'h300);
      @(negedge clk);
      din = 12'h100;
      shift_hist(12'h100);
      qa.push_back(model(1'b0));
      qb.push_back(model(1'b0));
      @(negedge clk);
      start = 1'b0;
      exp_a = qa.pop_front();
      exp_b = qb.pop_front();
      @(negedge clk);
      checks++; if (out_a !== last_a) begin failures++; $display("FAIL restart_a_discard got=%h exp=%h", out_a, last_a); end
      @(negedge clk);
      checks++; if (out_a !== exp_a) begin failures++; $display("FAIL restart_a got=%h exp=%h", out_a, exp_a); end
      checks++; if (out_b !== last_b) begin failures++; $display("FAIL restart_b_early got=%h exp=%h", out_b, last_b); end
      @(negedge clk);
      checks++; if (out_b !== exp_b) begin failures++; $display("FAIL restart_b got=%h exp=%h", out_b, exp_b); end
      last_a = exp_a;
      last_b = exp_b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      imp_c[0] = 16384; imp_c[1] = 8192; imp_c[2] = 4096;
      imp_c[3] = 2048;  imp_c[4] = -16384; imp_c[5] = 1024;
      test_reset();
      test_impulse();
      test_saturation();
      test_en_hold();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
